// File: rtl/pe_mac_int.sv
// pe_mac_int: integer multiply-accumulate processing element for a systolic
// matrix multiplier. Operands are forwarded right/down one cycle later so the
// PE tiles into a grid. Products travel through a MUL_LAT-deep pipeline with
// valid/first/last tags. They are summed into a framed dot product with
// optional saturation and a sticky overflow flag.
//
// Handshake: there is no backpressure. A beat is accepted on every rising edge
// where in_valid=1. in_first and in_last only mean something when in_valid=1.
// res_valid is a one-cycle strobe. pe_result and res_ovf hold their value
// until the next strobe.
module pe_mac_int #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int MUL_LAT  = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    output logic              fwd_first,
    output logic              fwd_last,
    output logic              res_valid,
    output logic [ACC_W-1:0]  pe_result,
    output logic              res_ovf,
    output logic              busy,
    output logic              dbg_state
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;

    generate
        if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
            $error("pe_mac_int: DATA_W must be 8, 16 or 32");
        end
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("pe_mac_int: ACC_W must be >= 2*DATA_W");
        end
        if (MUL_LAT < 1) begin : g_bad_mul_lat
            $error("pe_mac_int: MUL_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // ---------------- forwarding registers ----------------
    logic [DATA_W-1:0] a_out_q, b_out_q;
    logic              fwd_valid_q, fwd_first_q, fwd_last_q;

    // Forward operands and sidebands to the neighbours, unconditionally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out_q     <= '0;
            b_out_q     <= '0;
            fwd_valid_q <= 1'b0;
            fwd_first_q <= 1'b0;
            fwd_last_q  <= 1'b0;
        end else begin
            a_out_q     <= a_in;
            b_out_q     <= b_in;
            fwd_valid_q <= in_valid;
            fwd_first_q <= in_first;
            fwd_last_q  <= in_last;
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_first = fwd_first_q;
    assign fwd_last  = fwd_last_q;

    // ---------------- multiplier pipeline ----------------
    logic [PROD_W-1:0] a_ext, b_ext, prod_d;

    // Extend the operands to the product width first. The low PROD_W bits of
    // the unsigned multiply are then correct for both signed and unsigned.
    always_comb begin
        a_ext  = {{DATA_W{(SIGNED != 0) && a_in[DATA_W-1]}}, a_in};
        b_ext  = {{DATA_W{(SIGNED != 0) && b_in[DATA_W-1]}}, b_in};
        prod_d = a_ext * b_ext;
    end

    logic [PROD_W-1:0]  mul_prod_q [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld_q, mul_first_q, mul_last_q;

    // Shift the product and its tags one stage per edge. Stage 0 captures the
    // new beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_prod_q[i] <= '0;
            end
            mul_vld_q   <= '0;
            mul_first_q <= '0;
            mul_last_q  <= '0;
        end else begin
            mul_prod_q[0]  <= prod_d;
            mul_vld_q[0]   <= in_valid;
            mul_first_q[0] <= in_valid & in_first;
            mul_last_q[0]  <= in_valid & in_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_prod_q[i]  <= mul_prod_q[i-1];
                mul_vld_q[i]   <= mul_vld_q[i-1];
                mul_first_q[i] <= mul_first_q[i-1];
                mul_last_q[i]  <= mul_last_q[i-1];
            end
        end
    end

    logic              acc_vld, acc_first, acc_last;
    logic [PROD_W-1:0] acc_prod;

    assign acc_vld   = mul_vld_q[MUL_LAT-1];
    assign acc_first = mul_first_q[MUL_LAT-1];
    assign acc_last  = mul_last_q[MUL_LAT-1];
    assign acc_prod  = mul_prod_q[MUL_LAT-1];

    // ---------------- frame FSM ----------------
    state_t state_q, state_d;
    logic   start_new;

    // Hold the frame state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A valid product closes the frame on last and opens or continues it otherwise.
    always_comb begin
        state_d = state_q;
        if (acc_vld) begin
            state_d = acc_last ? S_IDLE : S_ACC;
        end
    end

    // Status outputs. A beat with first set, or any beat arriving in IDLE, starts a fresh sum.
    always_comb begin
        start_new = acc_first || (state_q == S_IDLE);
        busy      = (|mul_vld_q) || (state_q == S_ACC);
        dbg_state = state_q;
    end

    // ---------------- accumulate stage ----------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_valid_q, res_valid_d;

    logic [SUM_W-1:0] prod_ext, base_ext, sum_w;
    logic [ACC_W-1:0] clamp_val, acc_next;
    logic             beat_ovf, ovf_total;

    // Add in one guard bit. Detect an out-of-range sum, then clamp or wrap it.
    always_comb begin
        prod_ext = {{(SUM_W - PROD_W){(SIGNED != 0) && acc_prod[PROD_W-1]}}, acc_prod};
        base_ext = start_new ? '0 : {(SIGNED != 0) && acc_q[ACC_W-1], acc_q};
        sum_w    = base_ext + prod_ext;

        if (SIGNED != 0) begin
            beat_ovf  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
            clamp_val = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            beat_ovf  = sum_w[ACC_W];
            clamp_val = '1;
        end

        acc_next  = (beat_ovf && (SATURATE != 0)) ? clamp_val : sum_w[ACC_W-1:0];
        ovf_total = (start_new ? 1'b0 : ovf_q) | beat_ovf;

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        res_d       = res_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = 1'b0;
        if (acc_vld) begin
            if (acc_last) begin
                res_d       = acc_next;
                res_ovf_d   = ovf_total;
                res_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = acc_next;
                ovf_d = ovf_total;
            end
        end
    end

    // Register the accumulator, the sticky flag and the published result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign pe_result = res_q;
    assign res_ovf   = res_ovf_q;
    assign res_valid = res_valid_q;

endmodule
